// File: rtl/regfile_byte_writer_pkg.sv
// rtl/regfile_byte_writer_pkg.sv - register-file parameter header shared by the byte-writer slice
package regfile_byte_writer_pkg;

  localparam int registerAddressLength = 4;
  localparam int dataLength            = 16;
  localparam int LANE_W                = dataLength / 2;
  localparam int REG_COUNT             = 2 ** registerAddressLength;

  typedef struct packed {
    logic                             valid;
    logic [registerAddressLength-1:0] add;
    logic                             lb;
    logic                             hb;
    logic [dataLength-1:0]            data;
  } pending_t;

endpackage

// File: rtl/regfile_byte_writer_if.sv
// rtl/regfile_byte_writer_if.sv - write request and dual read-port bundle of the byte-writer
interface regfile_byte_writer_if;
  import regfile_byte_writer_pkg::*;

  logic                             w_en;
  logic [registerAddressLength-1:0] w_regfile_add;
  logic                             w_lb;
  logic                             w_hb;
  logic [dataLength-1:0]            w_data;
  logic [registerAddressLength-1:0] r_add_a;
  logic [registerAddressLength-1:0] r_add_b;
  logic [dataLength-1:0]            r_data_a;
  logic [dataLength-1:0]            r_data_b;
  logic                             wb_pending;

  modport master (
    output w_en, w_regfile_add, w_lb, w_hb, w_data, r_add_a, r_add_b,
    input  r_data_a, r_data_b, wb_pending
  );

  modport slave (
    input  w_en, w_regfile_add, w_lb, w_hb, w_data, r_add_a, r_add_b,
    output r_data_a, r_data_b, wb_pending
  );

endinterface

// File: rtl/regfile_read_forward.sv
// rtl/regfile_read_forward.sv - per-lane merge of an array word with the pending write entry
module regfile_read_forward
  import regfile_byte_writer_pkg::*;
(
  input  logic [dataLength-1:0]            array_word,
  input  pending_t                         pend,
  input  logic [registerAddressLength-1:0] r_add,
  output logic [dataLength-1:0]            r_data
);

  logic hit;

  assign hit = pend.valid && (pend.add == r_add);

  assign r_data[LANE_W-1:0] = (hit && pend.lb) ? pend.data[LANE_W-1:0]
                                               : array_word[LANE_W-1:0];
  assign r_data[dataLength-1:LANE_W] = (hit && pend.hb) ? pend.data[dataLength-1:LANE_W]
                                                        : array_word[dataLength-1:LANE_W];

endmodule

// File: rtl/regfile_byte_writer.sv
// rtl/regfile_byte_writer.sv - 16x16 register file with byte-lane writes via a one-entry write-back stage
module regfile_byte_writer
  import regfile_byte_writer_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  regfile_byte_writer_if.slave      bus
);

  logic [dataLength-1:0] regs [REG_COUNT];
  pending_t              pend;
  logic                  capture;

  assign capture = bus.w_en && (bus.w_lb || bus.w_hb);

  // The old pending entry commits on the same edge a new one is captured,
  // so the array update always reads the pre-edge pending value.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        regs[i] <= '0;
      end
      pend <= '0;
    end else begin
      if (pend.valid && pend.lb) begin
        regs[pend.add][LANE_W-1:0] <= pend.data[LANE_W-1:0];
      end
      if (pend.valid && pend.hb) begin
        regs[pend.add][dataLength-1:LANE_W] <= pend.data[dataLength-1:LANE_W];
      end
      pend.valid <= capture;
      if (capture) begin
        pend.add  <= bus.w_regfile_add;
        pend.lb   <= bus.w_lb;
        pend.hb   <= bus.w_hb;
        pend.data <= bus.w_data;
      end
    end
  end

  assign bus.wb_pending = pend.valid;

  regfile_read_forward u_fwd_a (
    .array_word (regs[bus.r_add_a]),
    .pend       (pend),
    .r_add      (bus.r_add_a),
    .r_data     (bus.r_data_a)
  );

  regfile_read_forward u_fwd_b (
    .array_word (regs[bus.r_add_b]),
    .pend       (pend),
    .r_add      (bus.r_add_b),
    .r_data     (bus.r_data_b)
  );

endmodule
